// File: rtl/fetch_prefetch_stage.sv
// fetch_prefetch_stage: instruction fetch front end with credit-limited
// req/gnt issue, in-order prefetch queue and redirect flush of stale fetches.
module fetch_prefetch_stage #(
    parameter int          DEPTH    = 4,
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        CLK_50,
    input  logic        reset,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_gnt,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_rdata,
    input  logic        StallF,
    input  logic        redirect,
    input  logic [31:0] redirect_pc,
    output logic [31:0] InstrF,
    output logic [31:0] PCF_out,
    output logic [31:0] PCPlus8F,
    output logic        instr_valid
);
    localparam int CW = $clog2(DEPTH + 1);
    localparam int PW = $clog2(DEPTH);
    localparam logic [CW:0] DEPTH_C = (CW + 1)'(DEPTH);

    logic [31:0]   pc_q, pc_d;
    logic [CW-1:0] count_q, count_d, out_q, out_d, drop_q, drop_d;
    logic [PW-1:0] head_q, head_d, tail_q, tail_d, trd_q, trd_d, twr_q, twr_d;
    logic [31:0]   instr_mem [DEPTH];
    logic [31:0]   ipc_mem   [DEPTH];
    logic [31:0]   tag_mem   [DEPTH];
    logic [CW:0]   used;
    logic          issue, push, pop;

    always_comb begin
        used        = {1'b0, count_q} + {1'b0, out_q};
        imem_req    = !reset && !redirect && (used < DEPTH_C);
        imem_addr   = pc_q;
        issue       = imem_req && imem_gnt;
        // a response is dropped if it is stale or lands in a redirect cycle
        push        = imem_rvalid && drop_q == '0 && !redirect;
        instr_valid = count_q != '0;
        pop         = instr_valid && !StallF && !redirect;
        pc_d        = redirect ? (redirect_pc & 32'hFFFF_FFFC) : issue ? pc_q + 32'd4 : pc_q;
        out_d       = out_q + CW'(issue) - CW'(imem_rvalid);
        drop_d      = redirect ? out_d : drop_q - CW'(imem_rvalid && drop_q != '0);
        count_d     = redirect ? '0 : count_q + CW'(push) - CW'(pop);
        head_d      = redirect ? '0 : head_q + PW'(pop);
        tail_d      = redirect ? '0 : tail_q + PW'(push);
        trd_d       = trd_q + PW'(imem_rvalid);
        twr_d       = twr_q + PW'(issue);
        InstrF      = instr_valid ? instr_mem[head_q] : '0;
        PCF_out     = instr_valid ? ipc_mem[head_q] : '0;
        PCPlus8F    = instr_valid ? ipc_mem[head_q] + 32'd8 : '0;
    end

    always_ff @(posedge CLK_50 or posedge reset) begin
        if (reset) begin
            pc_q    <= RESET_PC;
            count_q <= '0;
            out_q   <= '0;
            drop_q  <= '0;
            head_q  <= '0;
            tail_q  <= '0;
            trd_q   <= '0;
            twr_q   <= '0;
        end else begin
            pc_q    <= pc_d;
            count_q <= count_d;
            out_q   <= out_d;
            drop_q  <= drop_d;
            head_q  <= head_d;
            tail_q  <= tail_d;
            trd_q   <= trd_d;
            twr_q   <= twr_d;
        end
    end

    // tag FIFO keeps the PC of every in-flight request, stale or not
    always_ff @(posedge CLK_50) begin
        if (push) begin
            instr_mem[tail_q] <= imem_rdata;
            ipc_mem[tail_q]   <= tag_mem[trd_q];
        end
        if (issue)
            tag_mem[twr_q] <= pc_q;
    end

    always_ff @(posedge CLK_50) begin
        if (!reset && imem_rvalid)
            assert (out_q != '0);
    end
endmodule

// File: tb/tb_fetch_prefetch_stage.sv
// tb_fetch_prefetch_stage: table vectors, directed corner sequences and random
// traffic against a queue-based reference model and in-order memory model.
module tb_fetch_prefetch_stage;
    localparam int          DEPTH = 4;
    localparam logic [31:0] RPC   = 32'h0000_0000;

    logic        CLK_50, reset, imem_req, imem_gnt, imem_rvalid, StallF, redirect, instr_valid;
    logic [31:0] imem_addr, imem_rdata, redirect_pc, InstrF, PCF_out, PCPlus8F;

    fetch_prefetch_stage #(.DEPTH(DEPTH), .RESET_PC(RPC)) dut (
        .CLK_50(CLK_50), .reset(reset), .imem_req(imem_req), .imem_addr(imem_addr),
        .imem_gnt(imem_gnt), .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
        .StallF(StallF), .redirect(redirect), .redirect_pc(redirect_pc),
        .InstrF(InstrF), .PCF_out(PCF_out), .PCPlus8F(PCPlus8F), .instr_valid(instr_valid)
    );

    initial CLK_50 = 0;
    always #5 CLK_50 = ~CLK_50;

    typedef struct {logic [31:0] a; bit stale;} fl_t;
    typedef struct {logic [31:0] i; logic [31:0] p;} qe_t;
    typedef struct {logic [31:0] a; int t;} pend_t;
    typedef struct {bit stall; bit req; bit valid; logic [31:0] instr;} vec_t;

    fl_t         m_fl[$];
    qe_t         m_q[$];
    pend_t       pend[$];
    logic [31:0] m_pc, salt, fa;
    bit          m_req, fired;
    int          cyc, last_t, lat_min, lat_max;
    int          errors, checks;
    vec_t        tbl[14];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic model_reset();
        m_fl.delete();
        m_q.delete();
        pend.delete();
        m_pc   = RPC;
        last_t = -1;
    endtask

    task automatic step_pre();
        imem_rvalid = pend.size() > 0 && pend[0].t <= cyc;
        imem_rdata  = imem_rvalid ? (pend[0].a ^ salt) : 32'hDEAD_BEEF;
        #2;
        m_req = !redirect && (m_q.size() + m_fl.size() < DEPTH);
        chk("imem_req", imem_req, m_req);
        if (m_req) chk("imem_addr", imem_addr, m_pc);
        chk("instr_valid", instr_valid, m_q.size() != 0);
        if (m_q.size() != 0) begin
            chk("InstrF", InstrF, m_q[0].i);
            chk("PCF_out", PCF_out, m_q[0].p);
            chk("PCPlus8F", PCPlus8F, m_q[0].p + 32'd8);
        end
        fired = imem_req && imem_gnt;
        fa    = imem_addr;
    endtask

    task automatic step_post();
        fl_t f;
        bit  have;
        int  t;
        @(posedge CLK_50);
        have = 0;
        if (imem_rvalid) begin
            have = m_fl.size() != 0;
            if (!have) chk("rvalid_has_request", 0, 1);
            else f = m_fl.pop_front();
        end
        if (m_q.size() != 0 && !StallF && !redirect) void'(m_q.pop_front());
        if (have && !f.stale && !redirect) m_q.push_back('{imem_rdata, f.a});
        if (redirect) begin
            m_q.delete();
            foreach (m_fl[k]) m_fl[k].stale = 1;
            m_pc = redirect_pc & 32'hFFFF_FFFC;
        end else if (m_req && imem_gnt) begin
            m_fl.push_back('{m_pc, 1'b0});
            m_pc += 32'd4;
        end
        if (imem_rvalid) void'(pend.pop_front());
        if (fired) begin
            t = cyc + $urandom_range(lat_max, lat_min);
            if (t <= last_t) t = last_t + 1;
            pend.push_back('{fa, t});
            last_t = t;
        end
        cyc++;
        #1;
    endtask

    task automatic step();
        step_pre();
        step_post();
    endtask

    task automatic reset_mid();
        #2;
        reset       = 1;
        imem_rvalid = 0;
        #1;
        chk("rst_req", imem_req, 0);
        chk("rst_valid", instr_valid, 0);
        chk("rst_instr", InstrF, 0);
        model_reset();
        @(posedge CLK_50);
        @(posedge CLK_50);
        #1;
        reset = 0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1);
    end

    initial begin
        bit found;
        int seen;
        tbl = '{
            '{0, 1, 0, 32'h0}, '{0, 1, 0, 32'h0}, '{1, 1, 1, 32'h0}, '{1, 1, 1, 32'h0},
            '{1, 0, 1, 32'h0}, '{1, 0, 1, 32'h0}, '{1, 0, 1, 32'h0}, '{1, 0, 1, 32'h0},
            '{0, 0, 1, 32'h0}, '{0, 1, 1, 32'h4}, '{0, 1, 1, 32'h8}, '{0, 1, 1, 32'hC},
            '{0, 1, 1, 32'h10}, '{0, 1, 1, 32'h14}};
        errors = 0; checks = 0; cyc = 0; salt = 0;
        lat_min = 1; lat_max = 1;
        reset = 1; imem_gnt = 0; imem_rvalid = 0; imem_rdata = 0;
        StallF = 0; redirect = 0; redirect_pc = 0;
        model_reset();
        #12;
        chk("reset_req", imem_req, 0);
        chk("reset_valid", instr_valid, 0);
        chk("reset_InstrF", InstrF, 0);
        chk("reset_PCF", PCF_out, 0);
        chk("reset_PCPlus8", PCPlus8F, 0);
        @(posedge CLK_50);
        #1;
        reset = 0;

        imem_gnt = 1;
        for (int i = 0; i < 14; i++) begin
            StallF = tbl[i].stall;
            step_pre();
            chk("tbl_req", imem_req, tbl[i].req);
            chk("tbl_valid", instr_valid, tbl[i].valid);
            if (tbl[i].valid) begin
                chk("tbl_instr", InstrF, tbl[i].instr);
                chk("tbl_pcf", PCF_out, tbl[i].instr);
            end
            step_post();
        end
        StallF = 0;
        for (int i = 0; i < 6; i++) step();

        // stale in-flight fetches with 3-cycle memory, then redirect to 0x103
        reset_mid();
        lat_min = 3; lat_max = 3; imem_gnt = 1;
        for (int i = 0; i < 40 && m_pc != 32'h18; i++) step();
        imem_gnt = 0;
        for (int i = 0; i < 20 && m_fl.size() > 2; i++) step();
        redirect = 1; redirect_pc = 32'h103;
        step();
        redirect = 0; imem_gnt = 1;
        step_pre();
        chk("redir_addr", imem_addr, 32'h100);
        step_post();
        found = 0;
        for (int i = 0; i < 20 && !found; i++) begin
            step_pre();
            if (instr_valid) begin
                found = 1;
                chk("redir_first_pcf", PCF_out, 32'h100);
                chk("redir_first_instr", InstrF, 32'h100 ^ salt);
            end
            step_post();
        end
        chk("redir_valid_seen", found, 1);

        // redirect in the same cycle the 0x20 response returns
        reset_mid();
        lat_min = 2; lat_max = 2; imem_gnt = 1;
        found = 0;
        for (int i = 0; i < 60 && !found; i++) begin
            if (pend.size() > 0 && pend[0].t <= cyc && pend[0].a == 32'h20) found = 1;
            else step();
        end
        chk("rvalid20_reached", found, 1);
        redirect = 1; redirect_pc = 32'h200;
        step();
        redirect = 0;
        seen = 0;
        found = 0;
        for (int i = 0; i < 12; i++) begin
            step_pre();
            if (instr_valid && PCF_out == 32'h20) seen++;
            if (instr_valid && !found) begin
                found = 1;
                chk("after20_first_pcf", PCF_out, 32'h200);
            end
            step_post();
        end
        chk("no_0x20", seen, 0);

        // PC wrap at the top of the address space
        lat_min = 1; lat_max = 1;
        redirect = 1; redirect_pc = 32'hFFFF_FFFE;
        step();
        redirect = 0;
        step_pre();
        chk("wrap_addr0", imem_addr, 32'hFFFF_FFFC);
        step_post();
        step_pre();
        chk("wrap_addr1", imem_addr, 32'h0);
        step_post();
        step_pre();
        chk("wrap_valid", instr_valid, 1);
        chk("wrap_pcf", PCF_out, 32'hFFFF_FFFC);
        chk("wrap_pc8", PCPlus8F, 32'h4);
        step_post();

        // asynchronous reset with three entries queued
        StallF = 1;
        for (int i = 0; i < 20 && m_q.size() != 3; i++) begin
            imem_gnt = (m_q.size() + m_fl.size()) < 3;
            step();
        end
        chk("three_queued", m_q.size(), 3);
        reset_mid();
        StallF = 0; imem_gnt = 1;
        step_pre();
        chk("restart_req", imem_req, 1);
        chk("restart_addr", imem_addr, RPC);
        step_post();

        // random traffic against the reference model
        salt = $urandom;
        lat_min = 1; lat_max = 4;
        for (int i = 0; i < 600; i++) begin
            imem_gnt    = $urandom_range(3, 0) != 0;
            StallF      = $urandom_range(3, 0) == 0;
            redirect    = $urandom_range(19, 0) == 0;
            redirect_pc = $urandom;
            step();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/fetch_prefetch_stage.md
Name: fetch_prefetch_stage

Overview:
- Instruction-fetch front end of the 5-stage ARM pipeline, directly upstream of the decode stage in the datapath.
- Owns PCF and issues word fetches to instruction memory over a req/gnt + rvalid handshake with variable latency.
- Buffers returned instructions in an in-order prefetch queue and presents one instruction per cycle to decode.
- Honours the decode stall (StallF) and the redirect from the branch/PC-write path, discarding stale in-flight fetches.

Parameters:
- DEPTH, 4: prefetch queue entries; also the cap on queue occupancy plus outstanding requests (power of 2, ≥2).
- RESET_PC, 32'h0000_0000: PC value loaded on reset.

Ports:
- CLK_50  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-high; clears all state.
- imem_req  out  1  fetch request valid.
- imem_addr  out  32  fetch word address; bits [1:0] always 0.
- imem_gnt  in  1  memory accepts the request this cycle.
- imem_rvalid  in  1  read data valid; responses return in request order, ≥1 cycle after grant.
- imem_rdata  in  32  instruction word.
- StallF  in  1  hold the current output; no pop.
- redirect  in  1  PC redirect (PCSrcW | BranchTakenE).
- redirect_pc  in  32  redirect target; bits [1:0] ignored (treated as 0).
- InstrF  out  32  instruction at queue head.
- PCF_out  out  32  address of InstrF.
- PCPlus8F  out  32  PCF_out + 8 (ARM R15 read value).
- instr_valid  out  1  queue head valid.

Behaviour:
- Reset (async): pc_q = RESET_PC, queue empty, outstanding = 0, drop = 0. Outputs: imem_req = 0 during reset; instr_valid = 0; InstrF = 0, PCF_out = 0, PCPlus8F = 0.
- Counters: count and outstanding are clog2(DEPTH+1) bits wide. drop is the same width.
- Credit:
  - imem_req = !reset & !redirect & (count + outstanding < DEPTH).
  - imem_addr = pc_q.
- Issue: a request fires on the cycle imem_req & imem_gnt. On issue: pc_q += 4 (mod 2^32 wrap) and outstanding += 1.
- Response: on imem_rvalid, outstanding -= 1.
  - If drop > 0: discard the word and decrement drop.
  - Otherwise: enqueue {imem_rdata, pc_of_that_request}. The PC is carried in a small in-order tag FIFO of depth DEPTH, written on issue.
- Pop: occurs when instr_valid & !StallF & !redirect.
  - InstrF, PCF_out and PCPlus8F are the queue head combinationally, so 0-cycle read latency from the head.
  - Output is stable while StallF = 1.
- Minimum latency: memory granting every cycle with 1-cycle rvalid gives a steady 1 instruction/cycle. First instr_valid appears 2 cycles after reset release.
- Redirect (highest priority):
  - Queue flushed (count = 0); pc_q = {redirect_pc[31:2], 2'b00}; no issue that cycle; no pop.
  - drop = outstanding (post-update value, after any response arriving this cycle is counted). A response arriving in the redirect cycle is discarded, not enqueued.
  - New fetches issue from the next cycle, with no dependency on drop reaching 0. Ordering guarantees the stale responses arrive first.
- Simultaneous events:
  - Push and pop in the same cycle: count unchanged.
  - Issue and response in the same cycle: outstanding unchanged.
  - Redirect while StallF = 1: redirect wins, and the queue is flushed.
- Full: when count + outstanding == DEPTH, imem_req = 0. The queue can never overflow; an imem_rvalid with no outstanding request is a protocol error (assertion).
- Reset mid-flight: all state is cleared immediately. The instruction memory shares reset, so no stale responses are expected afterwards.

Test Plan:
- Reset release, imem_gnt = 1, 1-cycle latency, memory returns addr as data, StallF = 0 -> InstrF sequence 0x0, 0x4, 0x8… one per cycle from cycle 2; PCPlus8F = PCF_out + 8.
- StallF = 1 for 6 cycles with DEPTH = 4, memory always granting -> imem_req drops after 4 credits are used; InstrF held at 0x0; on release, 0x0, 0x4, 0x8, 0xC delivered back-to-back.
- 3-cycle memory latency with 2 requests outstanding (0x10, 0x14), redirect to 0x103 -> both stale responses discarded; next imem_addr = 0x100; first InstrF = word@0x100 with PCF_out = 0x100.
- redirect asserted in the same cycle as imem_rvalid for 0x20 -> 0x20 never appears on InstrF; drop is counted without that response.
- pc_q = 0xFFFF_FFFC, issue -> next imem_addr = 0x0000_0000 (wrap); PCPlus8F for 0xFFFF_FFFC = 0x0000_0004.
- reset pulsed asynchronously mid-cycle with 3 entries queued -> instr_valid = 0 and imem_req = 0 immediately; after release, fetch restarts at RESET_PC.
